// File: rtl/crypt_pkg.sv
// Shared types for the cipher output serializer; checksum storage controlled by CRYPT_SER_CSUM_EN.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package crypt_pkg;

  localparam int BLK_BYTES = 4;

`ifdef CRYPT_SER_CSUM_EN
  localparam int LAST_IDX = 4;
`else
  localparam int LAST_IDX = 3;
`endif

  // lane[0] is encryptor OUT_1 and leaves first
  typedef struct packed {
`ifdef CRYPT_SER_CSUM_EN
    logic [7:0]                  csum;
`endif
    logic [BLK_BYTES-1:0][7:0]   lane;
  } crypt_blk_t;

  typedef enum logic {IDLE, SEND} ser_state_t;

  // Byte idx of a block in transmit order (lanes 1..4, then checksum if present)
  function automatic logic [7:0] blk_byte(input crypt_blk_t b, input logic [2:0] i);
    logic [7:0] r;
    r = b.lane[0];
    case (i)
      3'd0: r = b.lane[0];
      3'd1: r = b.lane[1];
      3'd2: r = b.lane[2];
      3'd3: r = b.lane[3];
`ifdef CRYPT_SER_CSUM_EN
      3'd4: r = b.csum;
`endif
      default: r = b.lane[0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crypt_blk_fifo.sv
// Single-clock FIFO of cipher blocks with occupancy count.
// Latency: head entry visible on rd_dat the cycle after its push.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module crypt_blk_fifo
  import crypt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        core_clk,
  input  logic                        arst,
  input  logic                        push,
  input  crypt_blk_t                  wr_dat,
  input  logic                        pop,
  output crypt_blk_t                  rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full,
  output logic                        empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  crypt_blk_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // full/empty come from the registered count only
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_dat  = mem[rd_ptr];

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge core_clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; only entries behind the pointers are ever read
  always_ff @(posedge core_clk) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/crypt_out_serializer.sv
// Buffers 4-lane cipher blocks and streams them lane 1..4 (+checksum under CRYPT_SER_CSUM_EN) as bytes.
// Latency: block pushed into an empty idle serializer at edge N shows its first byte after edge N+1.
// Backpressure: BYTE_OUT/BYTE_VALID hold while BYTE_READY=0; BLK_READY drops with DEPTH blocks queued.
module crypt_out_serializer
  import crypt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        BLK_VALID,
  input  logic [7:0]                  BLK_IN_1,
  input  logic [7:0]                  BLK_IN_2,
  input  logic [7:0]                  BLK_IN_3,
  input  logic [7:0]                  BLK_IN_4,
  output logic                        BLK_READY,
  output logic [7:0]                  BYTE_OUT,
  output logic                        BYTE_VALID,
  input  logic                        BYTE_READY,
  output logic [$clog2(DEPTH+1)-1:0]  LEVEL,
  output logic                        OVERFLOW
);
  localparam logic [2:0] LAST = 3'(LAST_IDX);

  crypt_blk_t fifo_wr_dat;
  crypt_blk_t fifo_rd_dat;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  ser_state_t state_q, state_d;
  crypt_blk_t blk_q, blk_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] byte_d;
  logic       vld_d;

  // pack lanes, and the checksum when enabled, into one FIFO entry
  always_comb begin
    fifo_wr_dat         = '0;
    fifo_wr_dat.lane[0] = BLK_IN_1;
    fifo_wr_dat.lane[1] = BLK_IN_2;
    fifo_wr_dat.lane[2] = BLK_IN_3;
    fifo_wr_dat.lane[3] = BLK_IN_4;
`ifdef CRYPT_SER_CSUM_EN
    fifo_wr_dat.csum    = BLK_IN_1 ^ BLK_IN_2 ^ BLK_IN_3 ^ BLK_IN_4;
`endif
  end

  crypt_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .core_clk (CLK),
    .arst     (RST),
    .push     (BLK_VALID),
    .wr_dat   (fifo_wr_dat),
    .pop      (pop),
    .rd_dat   (fifo_rd_dat),
    .count    (LEVEL),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign BLK_READY = ~fifo_full;

  // sticky record of a block dropped against a full FIFO
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        OVERFLOW <= 1'b0;
    else if (BLK_VALID && fifo_full) OVERFLOW <= 1'b1;
  end

  // serializer state, send register and registered byte outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      idx_q      <= '0;
      BYTE_OUT   <= 8'h00;
      BYTE_VALID <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      BYTE_OUT   <= byte_d;
      BYTE_VALID <= vld_d;
    end
  end

  // load head block, walk bytes on handshakes, chain the next block without a bubble
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    byte_d  = BYTE_OUT;
    vld_d   = BYTE_VALID;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          blk_d   = fifo_rd_dat;
          idx_d   = '0;
          byte_d  = fifo_rd_dat.lane[0];
          vld_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (BYTE_READY) begin
          if (idx_q != LAST) begin
            idx_d  = idx_q + 3'd1;
            byte_d = blk_byte(blk_q, idx_q + 3'd1);
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            blk_d  = fifo_rd_dat;
            idx_d  = '0;
            byte_d = fifo_rd_dat.lane[0];
          end else begin
            idx_d   = '0;
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_crypt_out_serializer.sv
// Self-checking bench for crypt_out_serializer: timed table vectors plus a byte scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding BYTE_READY low in several sequences.
module tb_crypt_out_serializer;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
`ifdef CRYPT_SER_CSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic          CLK, RST, BLK_VALID, BLK_READY, BYTE_VALID, BYTE_READY, OVERFLOW;
  logic [7:0]    BLK_IN_1, BLK_IN_2, BLK_IN_3, BLK_IN_4, BYTE_OUT;
  logic [LW-1:0] LEVEL;

  typedef struct packed {
    logic [7:0] l1, l2, l3, l4, cs;
  } vec_t;

  vec_t       vt [6];
  logic [7:0] exp_q [$];
  logic [7:0] sb_e;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         run;

  crypt_out_serializer #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BLK_VALID  (BLK_VALID),
    .BLK_IN_1   (BLK_IN_1),
    .BLK_IN_2   (BLK_IN_2),
    .BLK_IN_3   (BLK_IN_3),
    .BLK_IN_4   (BLK_IN_4),
    .BLK_READY  (BLK_READY),
    .BYTE_OUT   (BYTE_OUT),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .LEVEL      (LEVEL),
    .OVERFLOW   (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] vbyte(input vec_t v, input int k);
    case (k)
      0:       return v.l1;
      1:       return v.l2;
      2:       return v.l3;
      3:       return v.l4;
      default: return v.cs;
    endcase
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    vec_t v;
    v = '{a, b, c, d, a ^ b ^ c ^ d};
    return v;
  endfunction

  // drive one block for one edge; accepted blocks feed the scoreboard
  task automatic push_blk(input vec_t v, input bit accept);
    BLK_VALID = 1'b1;
    BLK_IN_1  = v.l1;
    BLK_IN_2  = v.l2;
    BLK_IN_3  = v.l3;
    BLK_IN_4  = v.l4;
    if (accept) for (int k = 0; k < NB; k++) exp_q.push_back(vbyte(v, k));
    tick();
    BLK_VALID = 1'b0;
  endtask

  // one block from idle with BYTE_READY=1, checked cycle by cycle
  task automatic run_single(input vec_t v, input string tag);
    BYTE_READY = 1'b1;
    push_blk(v, 1'b1);
    chk({tag, "_vld_pre"}, 32'(BYTE_VALID), 0);
    chk({tag, "_lvl_pre"}, 32'(LEVEL), 1);
    for (int k = 0; k < NB; k++) begin
      tick();
      chk({tag, "_vld"},  32'(BYTE_VALID), 1);
      chk({tag, "_byte"}, 32'(BYTE_OUT), 32'(vbyte(v, k)));
    end
    tick();
    chk({tag, "_vld_end"}, 32'(BYTE_VALID), 0);
    chk({tag, "_lvl_end"}, 32'(LEVEL), 0);
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    BYTE_READY = 1'b1;
    while ((exp_q.size() != 0 || BYTE_VALID) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_drain_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_drain_vld"},  32'(BYTE_VALID), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_byte_vld"},  32'(BYTE_VALID), 0);
    chk({tag, "_byte_out"},  32'(BYTE_OUT), 0);
    chk({tag, "_level"},     32'(LEVEL), 0);
    chk({tag, "_overflow"},  32'(OVERFLOW), 0);
    chk({tag, "_blk_ready"}, 32'(BLK_READY), 1);
  endtask

  // inputs move only just after rising edges, so the negedge view predicts the next handshake
  always @(negedge CLK) begin
    if (!RST && BYTE_VALID && BYTE_READY) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: got byte %0h, expected no byte at %0t", BYTE_OUT, $time);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_byte", 32'(BYTE_OUT), 32'(sb_e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h3C, 8'hDD, 8'hAC, 8'h23, 8'h6E};
    vt[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    vt[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    vt[3] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'hF0};
    vt[4] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    vt[5] = '{8'hA5, 8'h5A, 8'h0F, 8'hF1, 8'h01};

    RST        = 1'b1;
    BLK_VALID  = 1'b0;
    BLK_IN_1   = '0;
    BLK_IN_2   = '0;
    BLK_IN_3   = '0;
    BLK_IN_4   = '0;
    BYTE_READY = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    RST = 1'b0;
    tick();

    // table of single blocks, exact timing
    for (int i = 0; i < 6; i++) run_single(vt[i], $sformatf("single%0d", i));

    // backpressure on the first byte
    BYTE_READY = 1'b0;
    push_blk(vt[0], 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_vld",  32'(BYTE_VALID), 1);
      chk("bp_hold", 32'(BYTE_OUT), 32'h3C);
    end
    BYTE_READY = 1'b1;
    for (int k = 1; k < NB; k++) begin
      tick();
      chk("bp_byte", 32'(BYTE_OUT), 32'(vbyte(vt[0], k)));
    end
    tick();
    chk("bp_vld_end", 32'(BYTE_VALID), 0);

    // back-to-back blocks two cycles apart, no gap between them
    BYTE_READY = 1'b1;
    push_blk(vt[0], 1'b1);
    tick();
    chk("b2b_first_vld", 32'(BYTE_VALID), 1);
    chk("b2b_level0",    32'(LEVEL), 0);
    push_blk(vt[1], 1'b1);
    chk("b2b_level1",    32'(LEVEL), 1);
    run = 2;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!BYTE_VALID) break;
      run++;
    end
    chk("b2b_run",       32'(run), 32'(2 * NB));
    chk("b2b_level_end", 32'(LEVEL), 0);

    // push and pop on the same edge with one block queued
    BYTE_READY = 1'b0;
    push_blk(vt[2], 1'b1);
    tick();
    push_blk(vt[3], 1'b1);
    chk("sim_level_pre", 32'(LEVEL), 1);
    BYTE_READY = 1'b1;
    for (int c = 0; c < NB - 1; c++) tick();
    push_blk(vt[5], 1'b1);
    chk("sim_level_post", 32'(LEVEL), 1);
    chk("sim_head_byte",  32'(BYTE_OUT), 32'(vt[3].l1));
    drain("sim");

    // overflow: one block in send, DEPTH queued, one more dropped
    BYTE_READY = 1'b0;
    push_blk(mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 1'b1);
    tick();
    for (int j = 0; j < DEPTH; j++)
      push_blk(mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 1'b1);
    chk("ovf_level_full", 32'(LEVEL), DEPTH);
    chk("ovf_blk_ready",  32'(BLK_READY), 0);
    chk("ovf_flag_pre",   32'(OVERFLOW), 0);
    push_blk(mk(8'hDE, 8'hAD, 8'hBE, 8'hEF), 1'b0);
    chk("ovf_flag",       32'(OVERFLOW), 1);
    chk("ovf_level_kept", 32'(LEVEL), DEPTH);
    drain("ovf");
    chk("ovf_sticky",     32'(OVERFLOW), 1);
    chk("ovf_ready_back", 32'(BLK_READY), 1);

    // asynchronous reset after two bytes have gone out
    BYTE_READY = 1'b1;
    push_blk(vt[0], 1'b1);
    tick();
    tick();
    tick();
    chk("rst_pre_byte", 32'(BYTE_OUT), 32'hAC);
    #1 RST = 1'b1;
    #1;
    chk_reset("rst_mid");
    exp_q.delete();
    tick();
    RST = 1'b0;
    tick();
    run_single(vt[4], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
